// File: rtl/div_iter.sv
// Iterative restoring divider for the E stage: one quotient bit per cycle,
// stalls the pipeline until the quotient/remainder pair is ready.
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startE,
  input  logic              signedE,
  input  logic [DATA_W-1:0] aE,
  input  logic [DATA_W-1:0] bE,
  input  logic              stall_ext,
  input  logic              flush,
  output logic              div_stall,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi,
  output logic              result_valid,
  output logic [1:0]        o_dbg_state
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi;
  logic              r_qsign;
  logic              r_rsign;

  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_nx;
  logic [DATA_W-1:0] w_q_nx;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic              w_last;

  // Restoring step: shift the next dividend bit into the partial remainder,
  // keep the difference only when it did not go negative.
  assign w_shift  = {r_rem, r_q[DATA_W-1]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_ge     = ~w_diff[DATA_W];
  assign w_rem_nx = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign w_q_nx   = {r_q[DATA_W-2:0], w_ge};
  assign w_abs_a  = (signedE && aE[DATA_W-1]) ? -aE : aE;
  assign w_abs_b  = (signedE && bE[DATA_W-1]) ? -bE : bE;
  assign w_last   = (r_cnt == CW'(DATA_W - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (startE) w_next = (bE == '0) ? DONE : BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (!stall_ext) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_b     <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!flush) begin
        case (r_state)
          IDLE: if (startE) begin
            r_q     <= w_abs_a;
            r_rem   <= '0;
            r_b     <= w_abs_b;
            r_cnt   <= '0;
            r_qsign <= signedE & (aE[DATA_W-1] ^ bE[DATA_W-1]);
            r_rsign <= signedE & aE[DATA_W-1];
            // Divide by zero skips iteration: all-ones quotient, raw dividend.
            if (bE == '0) begin
              r_lo <= '1;
              r_hi <= aE;
            end
          end
          BUSY: begin
            r_q   <= w_q_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_lo <= r_qsign ? -w_q_nx : w_q_nx;
              r_hi <= r_rsign ? -w_rem_nx : w_rem_nx;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign div_stall    = ~rst & ~flush & (((r_state == IDLE) & startE) | (r_state == BUSY));
  assign result_lo    = r_lo;
  assign result_hi    = r_hi;
  assign result_valid = (r_state == DONE);
  assign o_dbg_state  = r_state;

endmodule
